// File: rtl/pe_sched_pkg.sv
// pe_sched_pkg: shared definitions for PE sequencing controllers.
//   state_t     - controller state encoding (IDLE, RUN, DRAIN, DONE)
//   KERNEL_ROWS - rows in the convolution kernel
//   PE_LAT_DEF  - default cycles from read issue to valid PE output
package pe_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int KERNEL_ROWS = 3;
  localparam int PE_LAT_DEF  = 3;

endpackage

// File: rtl/pe_sched_delay.sv
// pe_sched_delay: STAGES-deep shift register carrying {valid, address}.
// It shifts every cycle with no stall input, matching a PE pipeline that
// cannot be paused.
//   clk, rst  - clock, asynchronous active-low reset (clears all stages)
//   vld_in    - valid entering stage 0
//   addr_in   - address entering stage 0
//   vld_out   - valid leaving the last stage
//   addr_out  - address leaving the last stage
//   pending   - some stage other than the last holds a valid entry, i.e.
//               the line is not empty after the current cycle's shift
module pe_sched_delay #(
  parameter int STAGES = 3,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_in,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              vld_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              pending
);

  logic [STAGES-1:0] vld_p;
  logic [ADDR_W-1:0] addr_p [STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p <= '0;
      for (int i = 0; i < STAGES; i++) addr_p[i] <= '0;
    end else begin
      vld_p[0]  <= vld_in;
      addr_p[0] <= addr_in;
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i]  <= vld_p[i-1];
        addr_p[i] <= addr_p[i-1];
      end
    end
  end

  assign vld_out  = vld_p[STAGES-1];
  assign addr_out = addr_p[STAGES-1];

  if (STAGES > 1) begin : g_pend
    assign pending = |vld_p[STAGES-2:0];
  end else begin : g_nopend
    assign pending = 1'b0;
  end

endmodule

// File: rtl/pe_conv_scheduler.sv
// pe_conv_scheduler: sequencing controller for one processing element.
// Walks a 3x3 valid convolution over a C-channel WxH image, issuing one
// image/weight/partial-sum read per cycle (loop order c, r, y, x with x
// innermost) and writing each PE result back to the partial-sum BRAM
// PE_LAT cycles later.
//
// Ports:
//   clk, rst       - clock, asynchronous active-low reset
//   start          - layer start request, sampled only in IDLE
//   hold           - pauses read issue (in-flight results keep moving)
//   cfg_width/height/channels - image geometry, latched on accepted start
//   busy           - high in RUN and DRAIN
//   done           - one-cycle end-of-layer pulse
//   cfg_err        - one-cycle pulse one cycle after an illegal start
//   rd_en          - read strobe for image, weight and partial-sum BRAMs
//   img_addr       - ((c*H)+(y+r))*W + x
//   wt_addr        - c*3 + r
//   ps_addr        - y*Wo + x
//   psum_zero      - first pass (c=0, r=0): PE partial-sum input forced to 0
//   wr_en, wr_addr - partial-sum write-back, ps_addr delayed by PE_LAT
//   perf_hold_cnt  - saturating count of RUN cycles with hold high
//                    (present only when PE_SCHED_PERF_EN is defined)
//
// Build option: define PE_SCHED_PERF_EN to add perf_hold_cnt.
module pe_conv_scheduler
  import pe_sched_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 8,
  parameter int CH_W   = 6,
  parameter int PE_LAT = PE_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic [CH_W-1:0]   cfg_channels,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] img_addr,
  output logic [ADDR_W-1:0] wt_addr,
  output logic [ADDR_W-1:0] ps_addr,
  output logic              psum_zero,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
`ifdef PE_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_hold_cnt
`endif
);

  // Wide enough for C*H*W and for 2^ADDR_W without overflow.
  localparam int PROD_W = 2*DIM_W + CH_W;
  localparam int PW     = ((PROD_W > ADDR_W) ? PROD_W : ADDR_W) + 2;

  state_t state, state_nxt;

  logic [DIM_W-1:0]  w_q, wo_q, ho_q;
  logic [CH_W-1:0]   ch_q;
  logic [DIM_W-1:0]  x_q, y_q;
  logic [1:0]        r_q;
  logic [CH_W-1:0]   c_q;
  logic [ADDR_W-1:0] row_base_q;   // ((c*H)+(y+r))*W
  logic [ADDR_W-1:0] pass_base_q;  // ((c*H)+r)*W, row base at y=0
  logic [ADDR_W-1:0] ps_row_q;     // y*Wo
  logic [ADDR_W-1:0] wt_q;         // c*3 + r

  logic start_ok, start_bad, cfg_illegal;
  logic last_x, last_y, last_r, last_c, last_tuple;
  logic pending;

  // Legality is evaluated once per start from the raw config inputs; the
  // per-cycle address path below uses only adders.
  logic [DIM_W-1:0] wo_in, ho_in;
  logic [PW-1:0]    area_in, vol_in;

  assign wo_in   = cfg_width  - DIM_W'(2);
  assign ho_in   = cfg_height - DIM_W'(2);
  assign area_in = PW'(wo_in) * PW'(ho_in);
  assign vol_in  = PW'(cfg_channels) * PW'(cfg_height) * PW'(cfg_width);

  // Wo*Ho <= PE_LAT would let a pass re-read a partial sum before its
  // previous write lands. vol_in-1 is the highest image address.
  assign cfg_illegal = (cfg_width  < DIM_W'(3)) ||
                       (cfg_height < DIM_W'(3)) ||
                       (cfg_channels == '0)      ||
                       (area_in <= PW'(PE_LAT))  ||
                       (vol_in > (PW'(1) << ADDR_W));

  assign last_x     = (x_q == wo_q - DIM_W'(1));
  assign last_y     = (y_q == ho_q - DIM_W'(1));
  assign last_r     = (r_q == 2'(KERNEL_ROWS - 1));
  assign last_c     = (c_q == ch_q - CH_W'(1));
  assign last_tuple = last_x && last_y && last_r && last_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (cfg_illegal) begin
            start_bad = 1'b1;
          end else begin
            start_ok  = 1'b1;
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (!hold) begin
          rd_en = 1'b1;
          if (last_tuple) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // The final write may be on the line's last stage this cycle;
        // leaving now puts done one cycle after it.
        if (!pending) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cfg_err <= 1'b0;
    else      cfg_err <= start_bad;
  end

  // Loop counters and incremental address bases. On an x wrap the row base
  // steps by W; on a y wrap it returns to the pass base plus W (next kernel
  // row); on an r wrap the last row visited is H-1 of the channel, so one
  // more W lands exactly on the next channel's first row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_q         <= '0;
      wo_q        <= '0;
      ho_q        <= '0;
      ch_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      row_base_q  <= '0;
      pass_base_q <= '0;
      ps_row_q    <= '0;
      wt_q        <= '0;
    end else if (start_ok) begin
      w_q         <= cfg_width;
      wo_q        <= wo_in;
      ho_q        <= ho_in;
      ch_q        <= cfg_channels;
      x_q         <= '0;
      y_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      row_base_q  <= '0;
      pass_base_q <= '0;
      ps_row_q    <= '0;
      wt_q        <= '0;
    end else if (rd_en && !last_tuple) begin
      if (!last_x) begin
        x_q <= x_q + DIM_W'(1);
      end else begin
        x_q <= '0;
        if (!last_y) begin
          y_q        <= y_q + DIM_W'(1);
          row_base_q <= row_base_q + ADDR_W'(w_q);
          ps_row_q   <= ps_row_q + ADDR_W'(wo_q);
        end else begin
          y_q      <= '0;
          ps_row_q <= '0;
          wt_q     <= wt_q + ADDR_W'(1);
          if (!last_r) begin
            r_q         <= r_q + 2'd1;
            row_base_q  <= pass_base_q + ADDR_W'(w_q);
            pass_base_q <= pass_base_q + ADDR_W'(w_q);
          end else begin
            r_q         <= '0;
            c_q         <= c_q + CH_W'(1);
            row_base_q  <= row_base_q + ADDR_W'(w_q);
            pass_base_q <= row_base_q + ADDR_W'(w_q);
          end
        end
      end
    end
  end

  assign img_addr  = row_base_q + ADDR_W'(x_q);
  assign ps_addr   = ps_row_q + ADDR_W'(x_q);
  assign wt_addr   = wt_q;
  assign psum_zero = rd_en && (c_q == '0) && (r_q == 2'd0);

  // Read issue -> PE output boundary
  pe_sched_delay #(
    .STAGES (PE_LAT),
    .ADDR_W (ADDR_W)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .vld_in   (rd_en),
    .addr_in  (ps_addr),
    .vld_out  (wr_en),
    .addr_out (wr_addr),
    .pending  (pending)
  );

`ifdef PE_SCHED_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          perf_hold_cnt <= '0;
    else if (start_ok)                 perf_hold_cnt <= '0;
    else if (state == ST_RUN && hold)  perf_hold_cnt <= sat_inc32(perf_hold_cnt);
  end
`endif

endmodule
